// File: rtl/adder_measure_sequencer.sv
// Sequencer for a ring-oscillating adder: it loads the operands, lets the adder settle,
// counts the synchronized ring edges over a programmable window and reports the result.
module adder_measure_sequencer #(
  parameter int COUNT_W = 32,
  parameter int WIN_W   = 16,
  parameter int SETTLE  = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        a_value,
  input  logic [31:0]        b_value,
  input  logic [WIN_W-1:0]   window_cycles,
  input  logic               ring_in,
  output logic [31:0]        a_input,
  output logic [31:0]        b_input,
  output logic               ring_enable,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [2:0]         state;
  logic [31:0]        a_lat;
  logic [31:0]        b_lat;
  logic [WIN_W-1:0]   win_lat;
  logic [WIN_W-1:0]   win_cnt;
  logic [7:0]         settle_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               edge_ovf;
  logic               ring_s1;
  logic               ring_s2;
  logic               ring_s3;
  logic               ring_rise;

  // ring_s1/ring_s2 form the synchronizer; ring_s3 is only the edge-detect history.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ring_s1 <= 1'b0;
      ring_s2 <= 1'b0;
      ring_s3 <= 1'b0;
    end else begin
      ring_s1 <= ring_in;
      ring_s2 <= ring_s1;
      ring_s3 <= ring_s2;
    end
  end

  assign ring_rise   = ring_s2 & ~ring_s3;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign ring_enable = (state == S_SETTLE) || (state == S_MEASURE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      a_lat      <= '0;
      b_lat      <= '0;
      win_lat    <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      a_input    <= '0;
      b_input    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            a_lat   <= a_value;
            b_lat   <= b_value;
            win_lat <= window_cycles;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          a_input    <= a_lat;
          b_input    <= b_lat;
          settle_cnt <= SETTLE_LAST;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          edge_cnt <= '0;
          edge_ovf <= 1'b0;
          if (settle_cnt == 8'd0) begin
            if (win_lat == '0) begin
              state <= S_DONE;
            end else begin
              win_cnt <= win_lat - WIN_W'(1);
              state   <= S_MEASURE;
            end
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_MEASURE: begin
          // Saturate rather than wrap; the flag records that edges were lost.
          if (ring_rise) begin
            if (&edge_cnt) edge_ovf <= 1'b1;
            else           edge_cnt <= edge_cnt + COUNT_W'(1);
          end
          if (win_cnt == '0) state <= S_DONE;
          else               win_cnt <= win_cnt - WIN_W'(1);
        end
        S_DONE: begin
          count    <= edge_cnt;
          overflow <= edge_ovf;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
